counter_193_seq: RTL and testbench
==================================

COUNTER_193_SEQ -- requirements
Module: counter_193_seq

Interface
REQ-001 The block SHALL have parameter PULSE_W, default 1, giving the cycles per pulse phase (valid range 1..15).
REQ-002 The block SHALL have one clock and synchronous active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle and accepting
- cmd_op  in  2  00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
- cmd_arg  in  4  LOAD value, or UP/DOWN pulse count (0 means 16)
- done  out  1  one-cycle completion strobe
- wrapped  out  1  terminal count seen during last UP/DOWN
- clr  out  1  to counter, active high
- npl  out  1  to counter, active low
- cpu  out  1  to counter, count on rising edge
- cpd  out  1  to counter, count on rising edge
- p  out  4  to counter, parallel data
- q  in  4  from counter
- ntcu  in  1  from counter, active-low carry
- ntcd  in  1  from counter, active-low borrow

Function
REQ-003 The block SHALL accept a command on a rising edge when cmd_valid=1 and cmd_ready=1, registering cmd_op and cmd_arg; inputs SHALL be ignored at all other times.
REQ-004 cmd_ready SHALL be 1 only in IDLE.
REQ-005 States SHALL be IDLE, CLR, LOAD, LO, HI and DONE. Transitions: IDLE->CLR/LOAD/LO by op; CLR->DONE; LOAD->DONE; LO->HI; HI->LO while pulses remain, else HI->DONE; DONE->IDLE.
REQ-006 All counter-side outputs SHALL be registered and SHALL change on the edge following acceptance.
REQ-007 CLEAR SHALL drive clr=1 for PULSE_W cycles with npl=cpu=cpd=1.
REQ-008 LOAD SHALL drive p=cmd_arg and npl=0 for PULSE_W cycles; p SHALL hold that value until the next LOAD.
REQ-009 UP SHALL issue N pulses on cpu, each consisting of cpu=0 for PULSE_W cycles then cpu=1 for PULSE_W cycles, with cpd=1 throughout.
REQ-010 DOWN SHALL behave identically to UP, with the roles of cpd and cpu swapped.
REQ-011 done SHALL be 1 for exactly one cycle in DONE, and SHALL be 0 at all other times.
REQ-012 Latency from the acceptance edge to done SHALL be PULSE_W+1 cycles for CLEAR/LOAD and 2*N*PULSE_W+1 cycles for UP/DOWN.
REQ-013 wrapped SHALL clear on acceptance.
REQ-014 wrapped SHALL set if ntcu=0 (UP) or ntcd=0 (DOWN) is sampled in any LO cycle, and SHALL hold until the next acceptance.
REQ-015 At most one of clr=1, npl=0, cpu=0, cpd=0 SHALL be active in any cycle.
REQ-016 cmd_arg=0 SHALL yield 16 pulses; the count down-counter SHALL be 5 bits wide, with no wrap of its own.
REQ-017 cmd_valid held through a busy period SHALL be accepted in the first IDLE cycle, giving back-to-back throughput of one idle cycle between commands.

Reset
REQ-018 While reset=1 at an edge, the block SHALL enter IDLE with clr=0, npl=1, cpu=1, cpd=1, p=0, done=0, wrapped=0, cmd_ready=1 after the edge.
REQ-019 Reset mid-command SHALL abort without a done strobe; any counter pulse in progress SHALL be truncated with cpu/cpd returned high.

Structure
REQ-020 Op encodings, state encodings and the default PULSE_W SHALL live in the shared package counter_193_pkg.
REQ-021 The phase timer SHALL be one sub-module, phase_timer: a PULSE_W down-counter with load and expiry strobe.
REQ-022 The counter_193 device SHALL NOT be instantiated inside this block.

Verification
REQ-023 The bench SHALL pair the block with counter_193 and cover these directed scenarios:
- Reset, then CLEAR -> q=0000; done at acceptance+2 (PULSE_W=1).
- LOAD 1101, then UP 3 -> q=0000, wrapped=1, done at acceptance+7.
- LOAD 0010, then DOWN 2 -> q=0000, wrapped=0; then DOWN 1 -> q=1111, wrapped=1.
- UP with cmd_arg=0 from q=0101 -> 16 rising edges on cpu, q=0101, wrapped=1.
- PULSE_W=3, UP 1 -> cpu low exactly 3 cycles, done at acceptance+7; cmd_valid held during busy is accepted only in IDLE.
- Reset asserted mid-UP 8 -> next cycle cpu=1, cmd_ready=1, no done; every cycle, a checker asserts the one-hot-or-idle rule of REQ-015.

Source files
------------

// File: rtl/counter_193_pkg.sv
// Shared op/state encodings and defaults for the
// counter_193 command sequencer.
package counter_193_pkg;

  localparam int PULSE_W_DEF = 1;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_LO,
    S_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Pulse-phase timer: load arms PULSE_W cycles,
// expire is high in the last cycle of the phase.
module phase_timer
  import counter_193_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  logic [3:0] cnt;

  // count down from PULSE_W-1 to zero, then rest
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(PULSE_W - 1);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expire = (cnt == 4'd0);

endmodule

// File: rtl/counter_193_seq.sv
// Command sequencer driving an up/down counter:
// clear, load and timed up/down pulse trains.
module counter_193_seq
  import counter_193_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic       done,
  output logic       wrapped,
  output logic       clr,
  output logic       npl,
  output logic       cpu,
  output logic       cpd,
  output logic [3:0] p,
  input  logic [3:0] q,
  input  logic       ntcu,
  input  logic       ntcd
);

  state_e     state;
  op_e        op_r;
  logic [4:0] pulses;
  logic       tmr_load;
  logic       expire;
  logic       accept;

  // q is not needed for sequencing
  logic       unused_q;
  assign unused_q = ^q;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // arm the phase timer at the start of each phase
  always_comb begin
    tmr_load = 1'b0;
    case (state)
      S_IDLE:  tmr_load = accept;
      S_LO:    tmr_load = expire;
      S_HI:    tmr_load = expire && (pulses != 5'd1);
      default: tmr_load = 1'b0;
    endcase
  end

  phase_timer #(
    .PULSE_W(PULSE_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .expire(expire)
  );

  // sequencer FSM with registered counter-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_r    <= OP_CLEAR;
      pulses  <= 5'd0;
      done    <= 1'b0;
      wrapped <= 1'b0;
      clr     <= 1'b0;
      npl     <= 1'b1;
      cpu     <= 1'b1;
      cpd     <= 1'b1;
      p       <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r    <= op_e'(cmd_op);
            wrapped <= 1'b0;
            pulses  <= (cmd_arg == 4'd0) ? 5'd16
                                         : {1'b0, cmd_arg};
            unique case (op_e'(cmd_op))
              OP_CLEAR: begin
                clr   <= 1'b1;
                state <= S_CLR;
              end
              OP_LOAD: begin
                npl   <= 1'b0;
                p     <= cmd_arg;
                state <= S_LOAD;
              end
              OP_UP: begin
                cpu   <= 1'b0;
                state <= S_LO;
              end
              OP_DOWN: begin
                cpd   <= 1'b0;
                state <= S_LO;
              end
            endcase
          end
        end
        S_CLR: begin
          if (expire) begin
            clr   <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_LOAD: begin
          if (expire) begin
            npl   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_LO: begin
          if ((op_r == OP_UP && !ntcu) ||
              (op_r == OP_DOWN && !ntcd))
            wrapped <= 1'b1;
          if (expire) begin
            cpu   <= 1'b1;
            cpd   <= 1'b1;
            state <= S_HI;
          end
        end
        S_HI: begin
          if (expire) begin
            if (pulses == 5'd1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pulses <= pulses - 5'd1;
              state  <= S_LO;
              if (op_r == OP_UP) cpu <= 1'b0;
              else               cpd <= 1'b0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_193_seq.sv
// Bench: two sequencers (PULSE_W 1 and 3), each
// paired with a behavioural up/down counter.
module tb_counter_193_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid [2];
  logic [1:0] cmd_op    [2];
  logic [3:0] cmd_arg   [2];
  logic       cmd_ready [2];
  logic       done      [2];
  logic       wrapped   [2];
  logic       clr       [2];
  logic       npl       [2];
  logic       cpu       [2];
  logic       cpd       [2];
  logic [3:0] p         [2];
  logic [3:0] cq        [2];
  logic       ntcu      [2];
  logic       ntcd      [2];
  logic       pcpu      [2];
  logic       pcpd      [2];
  int         rise_u    [2];
  int         rise_d    [2];
  int         low_u     [2];

  int  n_pass = 0;
  int  n_total = 0;
  bit  armed = 1'b0;

  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] UP    = 2'b10;
  localparam logic [1:0] DOWN  = 2'b11;

  always #5 clk = ~clk;

  counter_193_seq #(.PULSE_W(1)) u0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_arg(cmd_arg[0]),
    .done(done[0]), .wrapped(wrapped[0]),
    .clr(clr[0]), .npl(npl[0]), .cpu(cpu[0]),
    .cpd(cpd[0]), .p(p[0]), .q(cq[0]),
    .ntcu(ntcu[0]), .ntcd(ntcd[0])
  );

  counter_193_seq #(.PULSE_W(3)) u1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_arg(cmd_arg[1]),
    .done(done[1]), .wrapped(wrapped[1]),
    .clr(clr[1]), .npl(npl[1]), .cpu(cpu[1]),
    .cpd(cpd[1]), .p(p[1]), .q(cq[1]),
    .ntcu(ntcu[1]), .ntcd(ntcd[1])
  );

  // behavioural 4-bit up/down counter device
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i] === 1'b1) cq[i] = 4'd0;
      else if (npl[i] === 1'b0) cq[i] = p[i];
      else begin
        if (cpu[i] === 1'b1 && pcpu[i] === 1'b0 && cpd[i] === 1'b1)
          cq[i] = cq[i] + 4'd1;
        if (cpd[i] === 1'b1 && pcpd[i] === 1'b0 && cpu[i] === 1'b1)
          cq[i] = cq[i] - 4'd1;
      end
      if (cpu[i] === 1'b1 && pcpu[i] === 1'b0) rise_u[i]++;
      if (cpd[i] === 1'b1 && pcpd[i] === 1'b0) rise_d[i]++;
      if (cpu[i] === 1'b0) low_u[i]++;
      pcpu[i] = cpu[i];
      pcpd[i] = cpd[i];
    end
  end

  // terminal count outputs of the device
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ntcu[i] = !(cq[i] == 4'd15 && cpu[i] == 1'b0);
      ntcd[i] = !(cq[i] == 4'd0 && cpd[i] == 1'b0);
    end
  end

  task automatic tick();
    int act;
    @(negedge clk);
    #1;
    if (armed && !reset) begin
      for (int i = 0; i < 2; i++) begin
        act = int'(clr[i]) + int'(!npl[i]) +
              int'(!cpu[i]) + int'(!cpd[i]);
        n_total++;
        if (act > 1)
          $display("FAIL onehot u%0d: %0d active, need <=1",
                   i, act);
        else n_pass++;
      end
    end
  endtask

  task automatic run_cmd(input int d, input logic [1:0] op,
                         input logic [3:0] arg, input bit hold,
                         output int lat);
    int w;
    w = 0;
    while (cmd_ready[d] !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_arg[d]   = arg;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid[d] = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done[d] === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] got;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_op[d]    = 2'b00;
      cmd_arg[d]   = 4'd0;
    end
    repeat (3) @(posedge clk);
    tick();
    for (int d = 0; d < 2; d++) begin
      got = {clr[d], npl[d], cpu[d], cpd[d], p[d],
             done[d], wrapped[d], cmd_ready[d]};
      n_total++;
      if (got !== 11'b0111_0000_001)
        $display("FAIL reset u%0d: got %b need 01110000001",
                 d, got);
      else n_pass++;
    end
    reset = 1'b0;
    armed = 1'b1;
  endtask

  task automatic test_clear();
    int lat;
    run_cmd(0, LOAD, 4'b1001, 1'b0, lat);
    run_cmd(0, CLEAR, 4'd0, 1'b0, lat);
    n_total++;
    if (lat !== 2) $display("FAIL clear_lat: got %0d need 2", lat);
    else n_pass++;
    n_total++;
    if (cq[0] !== 4'd0) $display("FAIL clear_q: got %h need 0", cq[0]);
    else n_pass++;
  endtask

  task automatic test_up_wrap();
    int lat;
    run_cmd(0, LOAD, 4'b1101, 1'b0, lat);
    n_total++;
    if (cq[0] !== 4'b1101 || p[0] !== 4'b1101)
      $display("FAIL load_q: got %h/%h need d", cq[0], p[0]);
    else n_pass++;
    run_cmd(0, UP, 4'd3, 1'b0, lat);
    n_total++;
    if (lat !== 7) $display("FAIL up3_lat: got %0d need 7", lat);
    else n_pass++;
    n_total++;
    if (cq[0] !== 4'd0 || wrapped[0] !== 1'b1)
      $display("FAIL up3: got q=%h w=%b need q=0 w=1",
               cq[0], wrapped[0]);
    else n_pass++;
  endtask

  task automatic test_down();
    int lat;
    run_cmd(0, LOAD, 4'b0010, 1'b0, lat);
    run_cmd(0, DOWN, 4'd2, 1'b0, lat);
    n_total++;
    if (cq[0] !== 4'd0 || wrapped[0] !== 1'b0 || lat !== 5)
      $display("FAIL down2: got q=%h w=%b lat=%0d need 0/0/5",
               cq[0], wrapped[0], lat);
    else n_pass++;
    run_cmd(0, DOWN, 4'd1, 1'b0, lat);
    n_total++;
    if (cq[0] !== 4'hf || wrapped[0] !== 1'b1 || lat !== 3)
      $display("FAIL down1: got q=%h w=%b lat=%0d need f/1/3",
               cq[0], wrapped[0], lat);
    else n_pass++;
  endtask

  task automatic test_up16();
    int lat;
    int r0;
    run_cmd(0, LOAD, 4'b0101, 1'b0, lat);
    r0 = rise_u[0];
    run_cmd(0, UP, 4'd0, 1'b0, lat);
    n_total++;
    if (rise_u[0] - r0 !== 16)
      $display("FAIL up16_edges: got %0d need 16", rise_u[0] - r0);
    else n_pass++;
    n_total++;
    if (cq[0] !== 4'b0101 || wrapped[0] !== 1'b1 || lat !== 33)
      $display("FAIL up16: got q=%h w=%b lat=%0d need 5/1/33",
               cq[0], wrapped[0], lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int l0;
    int w;
    l0 = low_u[1];
    run_cmd(1, UP, 4'd1, 1'b1, lat);
    n_total++;
    if (lat !== 7) $display("FAIL pw3_lat: got %0d need 7", lat);
    else n_pass++;
    n_total++;
    if (low_u[1] - l0 !== 3)
      $display("FAIL pw3_low: got %0d need 3", low_u[1] - l0);
    else n_pass++;
    tick();
    n_total++;
    if (cmd_ready[1] !== 1'b1 || done[1] !== 1'b0)
      $display("FAIL b2b_idle: got rdy=%b done=%b need 1/0",
               cmd_ready[1], done[1]);
    else n_pass++;
    tick();
    cmd_valid[1] = 1'b0;
    n_total++;
    if (cmd_ready[1] !== 1'b0 || cpu[1] !== 1'b0)
      $display("FAIL b2b_accept: got rdy=%b cpu=%b need 0/0",
               cmd_ready[1], cpu[1]);
    else n_pass++;
    w = 0;
    while (done[1] !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_total++;
    if (done[1] !== 1'b1) $display("FAIL b2b_done: got 0 need 1");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = UP;
    cmd_arg[0]   = 4'd8;
    @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    repeat (5) tick();
    n_total++;
    if (cpu[0] !== 1'b0) $display("FAIL mid_lo: got cpu=%b need 0", cpu[0]);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (cpu[0] !== 1'b1 || cmd_ready[0] !== 1'b1 || done[0] !== 1'b0)
      $display("FAIL mid_reset: got cpu=%b rdy=%b done=%b need 1/1/0",
               cpu[0], cmd_ready[0], done[0]);
    else n_pass++;
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      tick();
      if (done[0] === 1'b1) dones++;
    end
    n_total++;
    if (dones !== 0) $display("FAIL mid_nodone: got %0d need 0", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    int v;
    int n;
    int r0;
    logic [1:0] op;
    logic [3:0] arg;
    logic [3:0] eq;
    logic ew;
    for (int it = 0; it < 24; it++) begin
      v   = int'($urandom_range(0, 15));
      op  = ($urandom_range(0, 1) == 0) ? UP : DOWN;
      arg = 4'($urandom_range(0, 15));
      n   = (arg == 4'd0) ? 16 : int'(arg);
      run_cmd(0, LOAD, 4'(v), 1'b0, lat);
      r0 = (op == UP) ? rise_u[0] : rise_d[0];
      run_cmd(0, op, arg, 1'b0, lat);
      if (op == UP) begin
        eq = 4'((v + n) % 16);
        ew = (v + n > 15);
      end else begin
        eq = 4'((v - n + 32) % 16);
        ew = (n > v);
      end
      n_total++;
      if (cq[0] !== eq || wrapped[0] !== ew || lat !== 2 * n + 1)
        $display("FAIL rnd%0d: got q=%h w=%b lat=%0d need %h/%b/%0d",
                 it, cq[0], wrapped[0], lat, eq, ew, 2 * n + 1);
      else n_pass++;
      n_total++;
      if (((op == UP) ? rise_u[0] : rise_d[0]) - r0 !== n)
        $display("FAIL rnd%0d_edges: need %0d", it, n);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cq[i]     = 4'd0;
      pcpu[i]   = 1'b1;
      pcpd[i]   = 1'b1;
      rise_u[i] = 0;
      rise_d[i] = 0;
      low_u[i]  = 0;
    end
  end

  initial begin
    test_reset();
    test_clear();
    test_up_wrap();
    test_down();
    test_up16();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
